// File: rtl/phy_tx_serializer_pkg.sv
// Shared PHY definitions: comma byte, frame geometry,
// and the word-to-lane byte striping used by the serializer.
package phy_tx_serializer_pkg;

  localparam logic [7:0] COMMA = 8'hBC;
  localparam int FRAME_BITS = 16;
  localparam int LANES = 2;
  localparam int SYNC_FRAMES = 4;

  typedef logic [FRAME_BITS-1:0] frame_t;

  // Lane 0 carries bytes 3 and 1, lane 1 carries bytes 2 and 0.
  function automatic frame_t stripe(
    input logic [31:0] w,
    input logic        lane
  );
    frame_t f;
    if (lane) f = {w[23:16], w[7:0]};
    else      f = {w[31:24], w[15:8]};
    return f;
  endfunction

endpackage

// File: rtl/phy_tx_serializer_lane.sv
// One serial lane: 16-bit MSB-first shift register that
// loads a data stripe or the idle pattern at frame boundaries.
module phy_tx_lane
  import phy_tx_serializer_pkg::*;
#(
  parameter frame_t IDLE = {COMMA, COMMA}
) (
  input  logic   clk_32f,
  input  logic   reset,
  input  logic   load_data,
  input  logic   load_idle,
  input  logic   shift,
  input  frame_t data,
  output logic   serial
);

  frame_t shreg;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      shreg <= IDLE;
    end else begin
      unique case (1'b1)
        load_data: shreg <= data;
        load_idle: shreg <= IDLE;
        shift:     shreg <= {shreg[FRAME_BITS-2:0], 1'b0};
        default:   shreg <= shreg;
      endcase
    end
  end

  assign serial = shreg[FRAME_BITS-1];

endmodule

// File: rtl/phy_tx_serializer.sv
// Two-lane PHY transmit serializer: valid/ready word intake,
// comma sync preamble, then byte-striped MSB-first frames.
module phy_tx_serializer
  import phy_tx_serializer_pkg::FRAME_BITS;
  import phy_tx_serializer_pkg::LANES;
  import phy_tx_serializer_pkg::frame_t;
  import phy_tx_serializer_pkg::stripe;
#(
  parameter logic [7:0] COMMA = phy_tx_serializer_pkg::COMMA,
  parameter int SYNC_FRAMES = phy_tx_serializer_pkg::SYNC_FRAMES
) (
  input  logic        clk_32f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic        ready_out,
  output logic        data_out_0,
  output logic        data_out_1,
  output logic        frame_active
);

  localparam int BCW = $clog2(FRAME_BITS);
  localparam int SCW = $clog2(SYNC_FRAMES + 1);
  localparam logic [BCW-1:0] LAST_BIT = BCW'(FRAME_BITS - 1);
  localparam logic [SCW-1:0] SYNC_END = SCW'(SYNC_FRAMES);

  logic [BCW-1:0] bit_cnt;
  logic [SCW-1:0] sync_cnt;
  logic [31:0]    hold_data;
  logic           hold_full;
  logic           sync_done;
  logic           boundary;
  logic           accept;
  logic [LANES-1:0] lane_bit;

  assign boundary  = (bit_cnt == LAST_BIT);
  assign sync_done = (sync_cnt == SYNC_END);
  assign ready_out = sync_done && !hold_full;
  assign accept    = valid_in && ready_out;

  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      bit_cnt  <= '0;
      sync_cnt <= '0;
    end else begin
      bit_cnt <= bit_cnt + 1'b1;
      if (boundary && !sync_done)
        sync_cnt <= sync_cnt + 1'b1;
    end
  end

  // hold_full is never set while full, so accept and the
  // boundary drain cannot collide on the same word.
  always_ff @(posedge clk_32f or posedge reset) begin
    if (reset) begin
      hold_data    <= '0;
      hold_full    <= 1'b0;
      frame_active <= 1'b0;
    end else begin
      if (boundary)
        frame_active <= hold_full;
      if (accept) begin
        hold_data <= data_in;
        hold_full <= 1'b1;
      end else if (boundary) begin
        hold_full <= 1'b0;
      end
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    phy_tx_lane #(
      .IDLE ({COMMA, COMMA})
    ) u_lane (
      .clk_32f   (clk_32f),
      .reset     (reset),
      .load_data (boundary && hold_full),
      .load_idle (boundary && !hold_full),
      .shift     (!boundary),
      .data      (stripe(hold_data, 1'(i))),
      .serial    (lane_bit[i])
    );
  end

  assign data_out_0 = lane_bit[0];
  assign data_out_1 = lane_bit[1];

endmodule
